// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the PRBS checker: step taps, reset seed and FSM encoding.
// The step function is the single source of truth for the sequence polynomial.
package prbs_checker_pkg;

   localparam int unsigned PrbsTapA = 31;
   localparam int unsigned PrbsTapB = 26;
   localparam int unsigned PrbsTapC = 15;
   localparam logic [31:0] PrbsSeed = 32'h0000_ACE1;

   typedef enum logic [0:0] {
      StSearch = 1'b0,
      StLocked = 1'b1
   } state_e;

   function automatic logic [31:0] prbs_step(input logic [31:0] x);
      return {x[30:0], x[PrbsTapA] ^ x[PrbsTapB] ^ x[PrbsTapC]};
   endfunction

endpackage

// File: rtl/prbs_checker_prbs.sv
// PRBS state register: reload from a seed, or advance one step per run pulse.
// Reload wins over run so a reseed is never lost.
module prbs_checker_prbs
   import prbs_checker_pkg::*;
(
   input  logic        i_aclk,
   input  logic        i_aresetn,
   input  logic        i_prbs_reload,
   input  logic [31:0] i_prbs_seed,
   input  logic        i_prbs_run,
   output logic [31:0] o_prbs_state
);

   logic [31:0] state_q;

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         state_q <= PrbsSeed;
      end else if (i_prbs_reload) begin
         state_q <= i_prbs_seed;
      end else if (i_prbs_run) begin
         state_q <= prbs_step(state_q);
      end
   end

   assign o_prbs_state = state_q;

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: reseeds from the stream while searching, free-runs once locked,
// counts accepted words and mismatches seen while locked.
module prbs_checker
   import prbs_checker_pkg::*;
#(
   parameter int unsigned LOCK_CNT   = 4,
   parameter int unsigned UNLOCK_CNT = 8
) (
   input  logic        i_aclk,
   input  logic        i_aresetn,
   input  logic        i_enable,
   input  logic        i_clear,
   input  logic [31:0] i_s_axis_tdata,
   input  logic        i_s_axis_tvalid,
   output logic        o_s_axis_tready,
   output logic        o_locked,
   output logic        o_err_pulse,
   output logic [31:0] o_err_cnt,
   output logic [31:0] o_word_cnt
);

   localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
   localparam int unsigned MissW  = $clog2(UNLOCK_CNT + 1);

   state_e              state_q, state_d;
   logic                tready_q;
   logic [MatchW-1:0]   match_cnt_q, match_cnt_d;
   logic [MissW-1:0]    miss_cnt_q, miss_cnt_d;
   logic [31:0]         err_cnt_q, err_cnt_d;
   logic [31:0]         word_cnt_q, word_cnt_d;
   logic                err_pulse_q, err_pulse_d;

   logic [31:0]         p_state, expected, prbs_seed;
   logic                beat, match, last_match, last_miss;
   logic                prbs_reload, prbs_run;

   // A beat arriving together with clear is discarded entirely.
   assign beat       = i_s_axis_tvalid & tready_q & ~i_clear;
   assign expected   = prbs_step(p_state);
   assign match      = (i_s_axis_tdata == expected);
   assign last_match = (match_cnt_q == MatchW'(LOCK_CNT - 1));
   assign last_miss  = (miss_cnt_q == MissW'(UNLOCK_CNT - 1));

   prbs_checker_prbs u_prbs (
      .i_aclk        (i_aclk),
      .i_aresetn     (i_aresetn),
      .i_prbs_reload (prbs_reload),
      .i_prbs_seed   (prbs_seed),
      .i_prbs_run    (prbs_run),
      .o_prbs_state  (p_state)
   );

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         state_q <= StSearch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (i_clear) begin
         state_d = StSearch;
      end else if (beat) begin
         case (state_q)
            StSearch: if (match && last_match) state_d = StLocked;
            StLocked: if (!match && last_miss) state_d = StSearch;
         endcase
      end
   end

   // Unlocking beat reseeds from the stream just like a search beat.
   always_comb begin
      prbs_reload = i_clear | (beat & ((state_q == StSearch) | (!match & last_miss)));
      prbs_run    = beat & (state_q == StLocked);
      prbs_seed   = i_clear ? PrbsSeed : i_s_axis_tdata;
      err_pulse_d = beat & (state_q == StLocked) & !match;
   end

   always_comb begin
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      err_cnt_d   = err_cnt_q;
      word_cnt_d  = word_cnt_q;
      if (i_clear) begin
         match_cnt_d = '0;
         miss_cnt_d  = '0;
         err_cnt_d   = '0;
         word_cnt_d  = '0;
      end else if (beat) begin
         if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 32'd1;
         if (state_q == StSearch) begin
            match_cnt_d = (match && !last_match) ? match_cnt_q + MatchW'(1) : '0;
         end else if (match) begin
            miss_cnt_d = '0;
         end else begin
            miss_cnt_d = last_miss ? '0 : miss_cnt_q + MissW'(1);
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         tready_q    <= 1'b0;
         match_cnt_q <= '0;
         miss_cnt_q  <= '0;
         err_cnt_q   <= '0;
         word_cnt_q  <= '0;
         err_pulse_q <= 1'b0;
      end else begin
         tready_q    <= i_enable;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         err_cnt_q   <= err_cnt_d;
         word_cnt_q  <= word_cnt_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   assign o_s_axis_tready = tready_q;
   assign o_locked        = (state_q == StLocked);
   assign o_err_pulse     = err_pulse_q;
   assign o_err_cnt       = err_cnt_q;
   assign o_word_cnt      = word_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed/random bench for prbs_checker against a behavioural model of the
// search/lock rules.
module tb_prbs_checker;

   localparam int unsigned LockCnt   = 4;
   localparam int unsigned UnlockCnt = 8;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        enable;
   logic        clear;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tready;
   logic        locked;
   logic        err_pulse;
   logic [31:0] err_cnt;
   logic [31:0] word_cnt;

   int total = 0;
   int bad   = 0;

   // Behavioural model state
   bit          m_rdy, m_locked, m_pulse;
   logic [31:0] m_p;
   int          m_mc, m_ms;
   logic [31:0] m_err, m_word;

   logic [31:0] g, w;
   bit          acc;

   prbs_checker #(
      .LOCK_CNT   (LockCnt),
      .UNLOCK_CNT (UnlockCnt)
   ) dut (
      .i_aclk          (aclk),
      .i_aresetn       (aresetn),
      .i_enable        (enable),
      .i_clear         (clear),
      .i_s_axis_tdata  (tdata),
      .i_s_axis_tvalid (tvalid),
      .o_s_axis_tready (tready),
      .o_locked        (locked),
      .o_err_pulse     (err_pulse),
      .o_err_cnt       (err_cnt),
      .o_word_cnt      (word_cnt)
   );

   always #5 aclk = ~aclk;

   function automatic logic [31:0] nxt(input logic [31:0] x);
      return {x[30:0], x[31] ^ x[26] ^ x[15]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_rdy = 0; m_locked = 0; m_pulse = 0; m_p = 32'h0000ACE1;
      m_mc = 0; m_ms = 0; m_err = 0; m_word = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".tready"}, {31'd0, tready}, {31'd0, m_rdy});
      chk({tag, ".locked"}, {31'd0, locked}, {31'd0, m_locked});
      chk({tag, ".pulse"}, {31'd0, err_pulse}, {31'd0, m_pulse});
      chk({tag, ".err"}, err_cnt, m_err);
      chk({tag, ".word"}, word_cnt, m_word);
   endtask

   // One clock: apply inputs, update model at the edge, compare 1 ns later.
   task automatic cycle(input logic v, input logic [31:0] d, input logic clr, output bit a);
      logic [31:0] e;
      tvalid = v; tdata = d; clear = clr;
      @(posedge aclk);
      a = v && m_rdy && !clr;
      m_pulse = 0;
      if (clr) begin
         m_locked = 0; m_p = 32'h0000ACE1; m_mc = 0; m_ms = 0; m_err = 0; m_word = 0;
      end else if (a) begin
         e = nxt(m_p);
         if (m_word != 32'hFFFFFFFF) m_word++;
         if (!m_locked) begin
            m_p = d;
            if (d == e) begin
               m_mc++;
               if (m_mc == LockCnt) begin m_locked = 1; m_mc = 0; end
            end else m_mc = 0;
         end else if (d == e) begin
            m_ms = 0; m_p = e;
         end else begin
            if (m_err != 32'hFFFFFFFF) m_err++;
            m_pulse = 1; m_ms++; m_p = e;
            if (m_ms == UnlockCnt) begin m_locked = 0; m_ms = 0; m_p = d; end
         end
      end
      m_rdy = enable;
      #1;
      check_all("cyc");
   endtask

   initial begin
      aresetn = 0; enable = 0; clear = 0; tdata = 0; tvalid = 0;
      model_reset();
      #3;
      check_all("reset");
      #9 aresetn = 1;
      @(posedge aclk); #1;
      enable = 1;
      cycle(0, 0, 0, acc);

      // Lock onto a stream starting at the reset seed.
      g = 32'h0000ACE1;
      cycle(1, g, 0, acc);
      for (int i = 0; i < 5; i++) begin
         g = nxt(g);
         cycle(1, g, 0, acc);
         if (i == 3) chk("lock_rise", {31'd0, locked}, 32'd1);
         if (i == 2) chk("lock_not_yet", {31'd0, locked}, 32'd0);
      end
      chk("lock_err", err_cnt, 32'd0);
      chk("lock_word", word_cnt, 32'd6);

      // Single bit-0 error while locked.
      for (int i = 0; i < 3; i++) begin g = nxt(g); cycle(1, g, 0, acc); end
      g = nxt(g);
      cycle(1, g ^ 32'd1, 0, acc);
      chk("flip_pulse", {31'd0, err_pulse}, 32'd1);
      g = nxt(g);
      cycle(1, g, 0, acc);
      chk("flip_pulse_gone", {31'd0, err_pulse}, 32'd0);
      chk("flip_err", err_cnt, 32'd1);
      chk("flip_locked", {31'd0, locked}, 32'd1);

      // Eight garbage words drop lock, then relock on the reseeded stream.
      for (int i = 0; i < 8; i++) begin
         g = nxt(g);
         w = $urandom;
         if (w == g) w = w ^ 32'd2;
         cycle(1, w, 0, acc);
         if (i == 6) chk("unlock_hold", {31'd0, locked}, 32'd1);
      end
      chk("unlock_fall", {31'd0, locked}, 32'd0);
      chk("unlock_err", err_cnt, 32'd9);
      g = w;
      for (int i = 0; i < 5; i++) begin g = nxt(g); cycle(1, g, 0, acc); end
      chk("relock", {31'd0, locked}, 32'd1);

      // Clear with a concurrent beat.
      g = nxt(g);
      cycle(1, g, 1, acc);
      chk("clear_word", word_cnt, 32'd0);
      chk("clear_err", err_cnt, 32'd0);
      chk("clear_locked", {31'd0, locked}, 32'd0);

      // Relock from the reset seed, then gappy traffic with an enable drop.
      g = 32'h0000ACE1;
      for (int i = 0; i < 4; i++) begin g = nxt(g); cycle(1, g, 0, acc); end
      chk("clear_relock", {31'd0, locked}, 32'd1);
      for (int i = 0; i < 40; i++) begin
         enable = !(i >= 10 && i < 20);
         cycle(1'($urandom_range(0, 1)), nxt(g), 0, acc);
         if (acc) g = nxt(g);
      end
      enable = 1;
      chk("gap_err", err_cnt, 32'd0);
      chk("gap_locked", {31'd0, locked}, 32'd1);

      // Asynchronous reset mid-stream.
      g = nxt(g);
      cycle(1, g, 0, acc);
      #2 aresetn = 0;
      #1;
      model_reset();
      check_all("async_reset");
      @(negedge aclk) aresetn = 1;
      tvalid = 0;
      @(posedge aclk); #1;
      m_rdy = enable;
      check_all("post_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter LOCK_CNT, default 4: consecutive matching beats in SEARCH needed to enter LOCKED.
REQ-002 Parameter UNLOCK_CNT, default 8: consecutive mismatching beats in LOCKED needed to return to SEARCH.
REQ-003 i_aclk  input  1  clock; all logic rising-edge.
REQ-004 i_aresetn  input  1  reset, asynchronous, active-low.
REQ-005 i_enable  input  1  checker enable; gates tready.
REQ-006 i_clear  input  1  synchronous clear of counters and state.
REQ-007 i_s_axis_tdata  input  32  received PRBS word.
REQ-008 i_s_axis_tvalid  input  1  beat valid.
REQ-009 o_s_axis_tready  output  1  beat ready.
REQ-010 o_locked  output  1  high in LOCKED state.
REQ-011 o_err_pulse  output  1  one-cycle pulse per mismatching beat in LOCKED.
REQ-012 o_err_cnt  output  32  mismatching beats counted in LOCKED.
REQ-013 o_word_cnt  output  32  all accepted beats.

Function
REQ-014 Beat accepted when i_s_axis_tvalid=1 and o_s_axis_tready=1.
REQ-015 o_s_axis_tready is registered copy of i_enable, one-cycle lag.
REQ-016 Step function: step(x) = {x[30:0], x[31]^x[26]^x[15]}.
REQ-017 Internal 32-bit state P holds last accepted (SEARCH) or predicted (LOCKED) word; expected word E = step(P).
REQ-018 Match = (tdata == E), evaluated only on accepted beats.
REQ-019 States: SEARCH, LOCKED; 2-state FSM.
REQ-020 SEARCH, accepted beat: P <= tdata (reseed); match increments consecutive-match count, mismatch zeroes it; no error counted.
REQ-021 SEARCH -> LOCKED on the accepted beat that brings match count to LOCK_CNT; match count then zeroed.
REQ-022 LOCKED, accepted beat: P <= E (free-run, no reseed); mismatch increments o_err_cnt, asserts o_err_pulse next cycle, increments consecutive-miss count; match zeroes miss count.
REQ-023 LOCKED -> SEARCH on the accepted beat that brings miss count to UNLOCK_CNT; that beat also reseeds P <= tdata; miss count zeroed.
REQ-024 No accepted beat: P, counts and state hold.
REQ-025 o_word_cnt increments on every accepted beat in either state.
REQ-026 o_err_cnt and o_word_cnt saturate at 0xFFFFFFFF.
REQ-027 All outputs registered; o_locked/counters reflect a beat one cycle after its acceptance.
REQ-028 i_clear=1: state SEARCH, both counters, match/miss counts zero, P = 0x0000ACE1; a beat accepted in the same cycle is discarded (not counted, not checked).
REQ-029 i_enable falling mid-stream: state and counts preserved; checking resumes on next accepted beat.

Reset
REQ-030 During reset: o_s_axis_tready=0, o_locked=0, o_err_pulse=0, o_err_cnt=0, o_word_cnt=0, state SEARCH, P=0x0000ACE1, match/miss counts 0.
REQ-031 Reset asserted mid-stream takes effect immediately (asynchronous); deassertion synchronous release assumed at system level.

Structure
REQ-032 Shared package holds the step taps (31,26,15), reset seed 0x0000ACE1 and FSM state encodings.
REQ-033 P implemented by instantiating the existing prbs sub-module: i_prbs_reload = SEARCH-accept or clear, i_prbs_seed = tdata (or reset seed on clear), i_prbs_run = LOCKED-accept.

Verification
REQ-034 Reset, enable, send 0x0000ACE1 then 5 successive step() words (0x000159C3 ...) -> o_locked rises one cycle after 5th beat; o_err_cnt=0, o_word_cnt=6.
REQ-035 Locked stream, flip bit 0 of one beat -> one o_err_pulse, o_err_cnt=1, o_locked stays 1, next correct beat matches.
REQ-036 Locked, send 8 consecutive random non-PRBS words -> o_locked falls after 8th beat, o_err_cnt=8; 5 further correct words re-lock.
REQ-037 Locked, assert i_clear with tvalid=1 same cycle -> next cycle counters 0, o_locked=0, beat not counted.
REQ-038 Locked, toggle tvalid randomly with gaps and drop i_enable for 10 cycles -> no errors, lock held, o_word_cnt equals accepted beats.
REQ-039 Assert i_aresetn=0 mid-stream -> all outputs at reset values in the same cycle.
